// File: rtl/reg_enc_pkg.sv
// Purpose: shared register-select types and sizes for the register file and its encoders/decoders.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_enc_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/priority_enc32.sv
// Purpose: lowest-set-bit encoder for a 32-bit vector, built as byte 8:3 encoders plus a 4:2 byte select.
// Latency: purely combinational.
// Backpressure: none; idx is 0 when no bit is set (any=0).
module priority_enc32 (
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        any
);

    logic [3:0]       byte_any;
    logic [3:0][2:0]  byte_idx;
    logic [1:0]       byte_sel;

    // Per-byte 8:3 encoders: lowest set bit within each byte wins.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            byte_any[b] = |vec[b*8 +: 8];
            byte_idx[b] = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (vec[b*8 + i]) begin
                    byte_idx[b] = 3'(i);
                end
            end
        end
    end

    // 4:2 stage: pick the lowest byte that has any bit set.
    always_comb begin
        byte_sel = 2'd0;
        for (int b = 3; b >= 0; b--) begin
            if (byte_any[b]) begin
                byte_sel = 2'(b);
            end
        end
    end

    assign idx = {byte_sel, byte_idx[byte_sel]};
    assign any = |byte_any;

endmodule

// File: rtl/reg_mask_encoder.sv
// Purpose: turns a register-list mask into lowest-first register indices for multi-register transfers.
// Latency: first index valid the cycle after start; one index per cycle with idx_ready held high.
// Backpressure: idx_valid/idx_ready; while idx_ready=0 the offered index, last and count hold stable.
module reg_mask_encoder
    import reg_enc_pkg::*;
#(
    parameter int WIDTH = REG_COUNT,
    parameter int IDX_W = REG_IDX_W,
    parameter int CNT_W = REG_IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             abort,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             last,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_nxt;
    logic             done_nxt;
    logic [IDX_W-1:0] low_idx;
    logic             low_any;
    logic [CNT_W-1:0] pop;
    logic             fire;

    priority_enc32 u_penc (
        .vec (pending),
        .idx (low_idx),
        .any (low_any)
    );

    // Number of registers still to be emitted for the current job.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CNT_W'(pending[i]);
        end
    end

    // pending is cleared whenever the job ends, so these outputs read 0 in IDLE.
    assign busy      = (state == RUN);
    assign idx_valid = (state == RUN) && low_any;
    assign idx_out   = low_idx;
    assign count     = pop;
    assign last      = idx_valid && (pop == CNT_W'(1));
    assign fire      = idx_valid && idx_ready;

    // Next-state: job launch from IDLE, lowest-bit retirement and abort in RUN.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // abort outranks start; an empty list completes without running
                if (!abort && start) begin
                    pending_nxt = mask_in;
                    if (mask_in != '0) begin
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    pending_nxt = '0;
                    state_nxt   = IDLE;
                end else if (fire) begin
                    // x & (x-1) drops exactly the lowest set bit, i.e. the one just accepted
                    pending_nxt = pending & (pending - WIDTH'(1));
                    if (last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    // State, pending list and registered completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Purpose: self-checking bench for reg_mask_encoder against a queue-based job model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: idx_ready driven directly (held, stalled, randomized).
module tb_reg_mask_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] mask_in;
    logic        abort;
    logic [4:0]  idx_out;
    logic        idx_valid;
    logic        idx_ready;
    logic        last;
    logic [5:0]  count;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    // model: remaining indices of the active job, in emission order
    int unsigned q[$];
    bit          m_busy;
    bit          m_done;

    reg_mask_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mask_in   (mask_in),
        .abort     (abort),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .last      (last),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees at that edge.
    task automatic model_update();
        bit nd;
        nd = 1'b0;
        if (reset) begin
            model_clear();
            return;
        end
        if (m_busy) begin
            if (abort) begin
                q.delete();
                m_busy = 1'b0;
            end else if (idx_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_busy = 1'b0;
                    nd = 1'b1;
                end
            end
        end else if (!abort && start) begin
            q.delete();
            for (int i = 0; i < 32; i++) begin
                if (mask_in[i]) q.push_back(i);
            end
            if (q.size() == 0) nd = 1'b1;
            else m_busy = 1'b1;
        end
        m_done = nd;
    endtask

    task automatic compare_all();
        chk("busy", busy, m_busy);
        chk("idx_valid", idx_valid, m_busy);
        chk("done", done, m_done);
        chk("count", count, q.size());
        chk("done_and_valid", done & idx_valid, 0);
        if (m_busy) begin
            chk("idx_out", idx_out, q[0]);
            chk("last", last, (q.size() == 1) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        int r;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        idx_ready = 1'b0;
        mask_in   = '0;
        model_clear();
        #1;
        chk("rst_valid", idx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_idx", idx_out, 0);
        chk("rst_last", last, 0);
        tick();
        #2 reset = 1'b0;
        tick();

        // 1: empty mask completes immediately
        start = 1'b1; mask_in = 32'h0000_0000;
        tick();
        start = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_valid", idx_valid, 0);
        tick();
        chk("t1_done_off", done, 0);
        chk("t1_valid2", idx_valid, 0);

        // 2: three indices back to back
        start = 1'b1; mask_in = 32'h8000_0011; idx_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_idx_a", idx_out, 0);  chk("t2_cnt_a", count, 3); chk("t2_last_a", last, 0);
        tick();
        chk("t2_idx_b", idx_out, 4);  chk("t2_cnt_b", count, 2); chk("t2_last_b", last, 0);
        tick();
        chk("t2_idx_c", idx_out, 31); chk("t2_cnt_c", count, 1); chk("t2_last_c", last, 1);
        tick();
        chk("t2_done", done, 1); chk("t2_busy", busy, 0);
        tick();
        chk("t2_done_off", done, 0);

        // 3: backpressure holds the offered index
        idx_ready = 1'b0; start = 1'b1; mask_in = 32'h0000_0006;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_idx", idx_out, 1);
            chk("t3_hold_cnt", count, 2);
            chk("t3_hold_vld", idx_valid, 1);
            tick();
        end
        chk("t3_idx_a", idx_out, 1);
        idx_ready = 1'b1;
        tick();
        chk("t3_idx_b", idx_out, 2); chk("t3_last_b", last, 1);
        tick();
        chk("t3_done", done, 1);

        // 4: start ignored while busy, then accepted in the done cycle; full mask
        idx_ready = 1'b0; start = 1'b1; mask_in = 32'h0000_0001;
        tick();
        mask_in = 32'hFFFF_FFFF;
        tick();
        chk("t4_ignored_cnt", count, 1);
        chk("t4_ignored_idx", idx_out, 0);
        start = 1'b0; idx_ready = 1'b1;
        tick();
        chk("t4_done1", done, 1);
        start = 1'b1; mask_in = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        chk("t4_cnt32", count, 32);
        for (int i = 0; i < 32; i++) begin
            chk("t4_seq_idx", idx_out, i);
            chk("t4_seq_cnt", count, 32 - i);
            tick();
        end
        chk("t4_done2", done, 1);

        // 5: abort mid-job with a simultaneous handshake, then restart
        start = 1'b1; mask_in = 32'h0000_000F; idx_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_idx_pre", idx_out, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0); chk("t5_cnt", count, 0);
        chk("t5_vld", idx_valid, 0); chk("t5_done", done, 0);
        start = 1'b1; mask_in = 32'h0000_0003;
        tick();
        start = 1'b0;
        chk("t5_restart_idx", idx_out, 0); chk("t5_restart_cnt", count, 2);
        tick();
        tick();
        chk("t5_restart_done", done, 1);
        abort = 1'b1; start = 1'b1; mask_in = 32'h0000_0005;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("t5_abort_idle_busy", busy, 0); chk("t5_abort_idle_done", done, 0);

        // 6: asynchronous reset mid-job
        idx_ready = 1'b0; start = 1'b1; mask_in = 32'h0000_00F0;
        tick();
        start = 1'b0;
        chk("t6_idx", idx_out, 4); chk("t6_cnt", count, 4);
        tick();
        #2 reset = 1'b1;
        model_clear();
        #1;
        compare_all();
        chk("t6_rst_vld", idx_valid, 0); chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", count, 0);     chk("t6_rst_idx", idx_out, 0);
        tick();
        #2 reset = 1'b0;
        idx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_post_vld", idx_valid, 0);
            chk("t6_post_done", done, 0);
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 7);
            case (r)
                0:       mask_in = 32'h0;
                1:       mask_in = 32'h1 << $urandom_range(0, 31);
                2:       mask_in = 32'hFFFF_FFFF;
                3:       mask_in = 32'h8000_0000;
                default: mask_in = $urandom & $urandom;
            endcase
            abort     = ($urandom_range(0, 19) == 0);
            idx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0; abort = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
